// File: rtl/key_debounce_events_if.sv
// Pushbutton conditioning signals between the board keys and the processor's button PIO.
// The slave side is the debouncer; the master side drives the raw keys and the sticky clears.
interface key_debounce_events_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n_in;
  logic [NUM_KEYS-1:0] key_n_out;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] long_pulse;
  logic [NUM_KEYS-1:0] press_sticky;
  logic [NUM_KEYS-1:0] sticky_clr;

  modport master (
    output key_n_in,
    output sticky_clr,
    input  key_n_out,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse,
    input  press_sticky
  );

  modport slave (
    input  key_n_in,
    input  sticky_clr,
    output key_n_out,
    output press_pulse,
    output release_pulse,
    output long_pulse,
    output press_sticky
  );
endinterface

// File: rtl/key_debounce_events.sv
// Per-key synchronizer, counter debounce FSM, press/release/long strobes and sticky press flags.
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_UP      | released and stable; key_n_out = 1
//   ST_DB_DOWN | low seen while released; counting stable-low cycles
//   ST_DOWN    | press accepted; key_n_out = 0; hold_cnt runs toward long press
//   ST_DB_UP   | high seen while pressed; counting stable-high cycles
module key_debounce_events #(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter int CNT_W           = 26
) (
  input logic                  CLOCK_50,
  input logic                  reset,
  key_debounce_events_if.slave kif
);

  typedef enum logic [1:0] {
    ST_UP,
    ST_DB_DOWN,
    ST_DOWN,
    ST_DB_UP
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [NUM_KEYS-1:0] sync_q1;
  logic [NUM_KEYS-1:0] key_sync;
  state_t              state    [NUM_KEYS];
  logic [CNT_W-1:0]    deb_cnt  [NUM_KEYS];
  logic [CNT_W-1:0]    hold_cnt [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_fired;
  logic [NUM_KEYS-1:0] key_lvl;
  logic [NUM_KEYS-1:0] press_q;
  logic [NUM_KEYS-1:0] release_q;
  logic [NUM_KEYS-1:0] long_q;
  logic [NUM_KEYS-1:0] sticky_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync_q1    <= '1;
      key_sync   <= '1;
      long_fired <= '0;
      key_lvl    <= '1;
      press_q    <= '0;
      release_q  <= '0;
      long_q     <= '0;
      sticky_q   <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i]    <= ST_UP;
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
      end
    end else begin
      sync_q1   <= kif.key_n_in;
      key_sync  <= sync_q1;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      // A press on the same edge overrides the clear below.
      sticky_q  <= sticky_q & ~kif.sticky_clr;
      for (int i = 0; i < NUM_KEYS; i++) begin
        case (state[i])
          ST_UP: begin
            if (!key_sync[i]) begin
              state[i]   <= ST_DB_DOWN;
              deb_cnt[i] <= '0;
            end
          end
          ST_DB_DOWN: begin
            if (key_sync[i]) begin
              state[i] <= ST_UP;
            end else if (deb_cnt[i] == DEB_LAST) begin
              state[i]    <= ST_DOWN;
              key_lvl[i]  <= 1'b0;
              press_q[i]  <= 1'b1;
              sticky_q[i] <= 1'b1;
              hold_cnt[i] <= '0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
            end
          end
          ST_DOWN: begin
            if (key_sync[i]) begin
              state[i]   <= ST_DB_UP;
              deb_cnt[i] <= '0;
            end else if (hold_cnt[i] == LONG_LAST && !long_fired[i]) begin
              long_q[i]     <= 1'b1;
              long_fired[i] <= 1'b1;
            end else if (hold_cnt[i] != LONG_LAST) begin
              hold_cnt[i] <= hold_cnt[i] + CNT_ONE;
            end
          end
          ST_DB_UP: begin
            // Returning to DOWN keeps hold_cnt and long_fired so a bounce cannot re-arm long press.
            if (!key_sync[i]) begin
              state[i] <= ST_DOWN;
            end else if (deb_cnt[i] == DEB_LAST) begin
              state[i]      <= ST_UP;
              key_lvl[i]    <= 1'b1;
              release_q[i]  <= 1'b1;
              long_fired[i] <= 1'b0;
            end else begin
              deb_cnt[i] <= deb_cnt[i] + CNT_ONE;
            end
          end
          default: state[i] <= ST_UP;
        endcase
      end
    end
  end

  assign kif.key_n_out     = key_lvl;
  assign kif.press_pulse   = press_q;
  assign kif.release_pulse = release_q;
  assign kif.long_pulse    = long_q;
  assign kif.press_sticky  = sticky_q;

endmodule

// File: tb/tb_key_debounce_events.sv
// Directed test-plan steps followed by random key activity, all checked every cycle
// against a run-length model of debounce, long-press and sticky behaviour.
module tb_key_debounce_events;
  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 10;
  localparam int CW   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  key_debounce_events_if #(.NUM_KEYS(NK)) kif ();

  key_debounce_events #(
    .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LONG), .CNT_W(CW)
  ) dut (
    .CLOCK_50(clk),
    .reset   (rst),
    .kif     (kif)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: inputs reach the decision logic two edges late; the level flips once
  // DEB+1 consecutive samples disagree with it; long press counts pressed edges whose
  // sample and previous sample are both low.
  logic [NK-1:0] m_d1, m_d2, m_last, m_lvl, m_fired;
  logic [NK-1:0] m_press, m_rel, m_long, m_sticky;
  int m_run [NK];
  int m_cnt [NK];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [NK-1:0] samp;
    if (rst) begin
      m_d1 = '1; m_d2 = '1; m_last = '1; m_lvl = '1; m_fired = '0;
      m_press = '0; m_rel = '0; m_long = '0; m_sticky = '0;
      for (int i = 0; i < NK; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
    end else begin
      samp = m_d2;
      m_d2 = m_d1;
      m_d1 = kif.key_n_in;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < NK; i++) begin
        if (samp[i] != m_lvl[i]) m_run[i]++;
        else m_run[i] = 0;
        if (m_run[i] == DEB + 1) begin
          m_lvl[i] = samp[i];
          m_run[i] = 0;
          if (!samp[i]) begin m_press[i] = 1'b1; m_cnt[i] = 0; end
          else begin m_rel[i] = 1'b1; m_fired[i] = 1'b0; end
        end else if (!m_lvl[i] && !samp[i] && !m_last[i]) begin
          if (m_cnt[i] < LONG) m_cnt[i]++;
          if (m_cnt[i] == LONG && !m_fired[i]) begin m_long[i] = 1'b1; m_fired[i] = 1'b1; end
        end
      end
      m_sticky = m_press | (m_sticky & ~kif.sticky_clr);
      m_last = samp;
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    chk("key_n_out", 32'(kif.key_n_out), 32'(m_lvl));
    chk("press_pulse", 32'(kif.press_pulse), 32'(m_press));
    chk("release_pulse", 32'(kif.release_pulse), 32'(m_rel));
    chk("long_pulse", 32'(kif.long_pulse), 32'(m_long));
    chk("press_sticky", 32'(kif.press_sticky), 32'(m_sticky));
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  int t0, pc, pe, act, bad;
  int hold_left [NK];

  initial begin
    rst = 1'b1;
    kif.key_n_in = '1;
    kif.sticky_clr = '0;

    // Reset and idle
    run(3);
    chk("rst_key_n_out", 32'(kif.key_n_out), 32'hF);
    chk("rst_strobes", 32'({kif.press_pulse, kif.release_pulse, kif.long_pulse}), 32'h0);
    chk("rst_sticky", 32'(kif.press_sticky), 32'h0);
    rst = 1'b0;
    act = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (|{kif.press_pulse, kif.release_pulse, kif.long_pulse, kif.press_sticky}) act++;
    end
    chk("idle_activity", 32'(act), 32'h0);

    // Clean press on key 0
    kif.key_n_in[0] = 1'b0;
    step();
    t0 = cyc;
    run(5);
    chk("press0_not_early", 32'(kif.key_n_out), 32'hF);
    step();
    chk("press0_level", 32'(kif.key_n_out), 32'hE);
    chk("press0_pulse", 32'(kif.press_pulse), 32'h1);
    chk("press0_sticky", 32'(kif.press_sticky), 32'h1);
    chk("press0_latency", 32'(cyc - t0), 32'd6);
    step();
    chk("press0_one_cycle", 32'(kif.press_pulse), 32'h0);

    // Bounce rejection on key 1
    pc = 0; pe = -1;
    for (int k = 0; k < 7; k++) begin
      kif.key_n_in[1] = (k == 3 || k == 6) ? 1'b1 : 1'b0;
      step();
      if (kif.press_pulse[1]) begin pc++; if (pe < 0) pe = cyc; end
    end
    kif.key_n_in[1] = 1'b0;
    step();
    t0 = cyc;
    if (kif.press_pulse[1]) begin pc++; if (pe < 0) pe = cyc; end
    for (int k = 0; k < 12; k++) begin
      step();
      if (kif.press_pulse[1]) begin pc++; if (pe < 0) pe = cyc; end
    end
    chk("bounce1_press_edge", 32'(pe - t0), 32'd6);
    chk("bounce1_press_count", 32'(pc), 32'd1);

    // Long press on key 2 with a one-cycle bounce at M+20
    kif.key_n_in[2] = 1'b0;
    step();
    run(6);
    chk("press2_pulse", 32'(kif.press_pulse[2]), 32'h1);
    t0 = cyc;
    pc = 0; pe = -1;
    for (int k = 1; k <= 100; k++) begin
      kif.key_n_in[2] = (k == 20) ? 1'b1 : 1'b0;
      step();
      if (kif.long_pulse[2]) begin pc++; if (pe < 0) pe = cyc; end
    end
    chk("long2_edge", 32'(pe - t0), 32'd10);
    chk("long2_count", 32'(pc), 32'd1);
    chk("long2_level_held", 32'(kif.key_n_out[2]), 32'h0);

    // Release key 0 through a high-high-low glitch
    pc = 0; pe = -1; bad = 0;
    for (int k = 0; k < 3; k++) begin
      kif.key_n_in[0] = (k == 2) ? 1'b0 : 1'b1;
      step();
      if (kif.key_n_out[0]) bad++;
      if (kif.release_pulse[0]) pc++;
    end
    kif.key_n_in[0] = 1'b1;
    step();
    t0 = cyc;
    for (int k = 0; k < 10; k++) begin
      if (kif.release_pulse[0]) begin pc++; if (pe < 0) pe = cyc; end
      if (kif.key_n_out[0] && cyc < t0 + 6) bad++;
      step();
    end
    chk("release0_edge", 32'(pe - t0), 32'd6);
    chk("release0_count", 32'(pc), 32'd1);
    chk("release0_glitch_level", 32'(bad), 32'd0);
    chk("release0_sticky_kept", 32'(kif.press_sticky[0]), 32'h1);

    // Sticky clear racing the press on key 3
    kif.key_n_in[3] = 1'b0;
    step();
    run(5);
    kif.sticky_clr[3] = 1'b1;
    step();
    chk("race3_pulse", 32'(kif.press_pulse[3]), 32'h1);
    chk("race3_set_wins", 32'(kif.press_sticky[3]), 32'h1);
    step();
    chk("race3_cleared", 32'(kif.press_sticky[3]), 32'h0);
    kif.sticky_clr[3] = 1'b0;

    // Reset while key 3 is debouncing a new press
    kif.key_n_in[3] = 1'b1;
    run(8);
    kif.key_n_in[3] = 1'b0;
    step();
    run(3);
    rst = 1'b1;
    run(2);
    chk("midrst_key_n_out", 32'(kif.key_n_out), 32'hF);
    chk("midrst_strobes", 32'({kif.press_pulse, kif.release_pulse, kif.long_pulse}), 32'h0);
    chk("midrst_sticky", 32'(kif.press_sticky), 32'h0);
    rst = 1'b0;
    pc = 0; pe = -1;
    step();
    t0 = cyc;
    if (kif.press_pulse[3]) begin pc++; if (pe < 0) pe = cyc; end
    for (int k = 0; k < 10; k++) begin
      step();
      if (kif.press_pulse[3]) begin pc++; if (pe < 0) pe = cyc; end
    end
    chk("midrst_press3_edge", 32'(pe - t0), 32'd6);
    chk("midrst_press3_count", 32'(pc), 32'd1);

    // Random key activity with occasional clears and resets
    for (int i = 0; i < NK; i++) hold_left[i] = 0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NK; i++) begin
        if (hold_left[i] == 0) begin
          kif.key_n_in[i] = 1'($urandom_range(0, 1));
          hold_left[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 30))
                                                      : int'($urandom_range(1, 8));
        end
        hold_left[i]--;
        kif.sticky_clr[i] = ($urandom_range(0, 7) == 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
